// File: rtl/ft245_cmd_ctrl_if.sv
// rtl/ft245_cmd_ctrl_if.sv - FT245 RX/TX byte streams and register-bank port bundle
interface ft245_cmd_ctrl_if;
  logic [7:0] rx_data_si;
  logic       rx_valid_si;
  logic       rx_ready_si;
  logic [7:0] tx_data_si;
  logic       tx_valid_si;
  logic       tx_ready_si;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;

  modport master (
    input  rx_data_si, rx_valid_si, tx_ready_si, reg_rd_data,
    output rx_ready_si, tx_data_si, tx_valid_si, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
  );

  modport slave (
    output rx_data_si, rx_valid_si, tx_ready_si, reg_rd_data,
    input  rx_ready_si, tx_data_si, tx_valid_si, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
  );
endinterface

// File: rtl/ft245_cmd_ctrl.sv
// rtl/ft245_cmd_ctrl.sv - host frame parser driving register writes/reads and 3-byte read responses
module ft245_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  RESP_BYTE      = 8'h5A,
  parameter logic [7:0]  CMD_WR         = 8'h01,
  parameter logic [7:0]  CMD_RD         = 8'h02,
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic                  clk,
  input  logic                  rst,
  ft245_cmd_ctrl_if.master      bus,
  output logic [7:0]            err_count
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_EXEC, S_RD_WAIT, S_TX_HDR, S_TX_ADDR, S_TX_DATA
  } state_t;

  state_t        state_q, state_d;
  logic          op_rd_q, op_rd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    resp_q, resp_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;
  logic [7:0]    err_q, err_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic rx_ready;
  logic rx_acc;
  logic tx_acc;
  logic in_frame;
  logic timeout;
  logic err_inc;

  // RX is only taken while parsing a frame; EXEC/RD_WAIT/TX states backpressure the host
  assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_ready = (state_q == S_IDLE) || in_frame;
  assign rx_acc   = bus.rx_valid_si & rx_ready;
  assign tx_acc   = tx_valid_q & bus.tx_ready_si;
  // an accepted byte in the expiry cycle wins over the abort
  assign timeout  = in_frame && !rx_acc && (tmo_q == TMO_LAST);

  assign bus.rx_ready_si = rx_ready;
  assign bus.tx_data_si  = tx_data_q;
  assign bus.tx_valid_si = tx_valid_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign err_count       = err_q;

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_rd_q    <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      resp_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 8'h00;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_rd_q    <= op_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  // frame parsing, strobes, response sequencing and inter-byte timeout
  always_comb begin
    state_d    = state_q;
    op_rd_d    = op_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    err_inc    = 1'b0;
    tmo_d      = (in_frame && !rx_acc) ? tmo_q + 1'b1 : '0;

    case (state_q)
      S_IDLE: begin
        if (rx_acc && bus.rx_data_si == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_acc) begin
          if (bus.rx_data_si == CMD_WR || bus.rx_data_si == CMD_RD) begin
            op_rd_d = (bus.rx_data_si == CMD_RD);
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ADDR: begin
        if (rx_acc) begin
          addr_d = bus.rx_data_si;
          if (op_rd_q) begin
            rd_en_d = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_acc) begin
          wdata_d = bus.rx_data_si;
          wr_en_d = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = op_rd_q ? S_RD_WAIT : S_IDLE;
      end
      S_RD_WAIT: begin
        resp_d     = bus.reg_rd_data;
        tx_data_d  = RESP_BYTE;
        tx_valid_d = 1'b1;
        state_d    = S_TX_HDR;
      end
      S_TX_HDR: begin
        if (tx_acc) begin
          tx_data_d = addr_q;
          state_d   = S_TX_ADDR;
        end
      end
      S_TX_ADDR: begin
        if (tx_acc) begin
          tx_data_d = resp_q;
          state_d   = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        if (tx_acc) begin
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      err_inc = 1'b1;
      state_d = S_IDLE;
      tmo_d   = '0;
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'h01 : err_q;
  end

endmodule
